// File: rtl/paddle_ctrl.sv
// Frame-rate paddle controller: button movement with field clamping, animated size
// power-ups and the SERVE/PLAY/DEAD sequence. Optional acceleration: PADDLE_ACCEL_EN.
module paddle_ctrl #(
    parameter int LEFT         = 160,
    parameter int MAXX         = 320,
    parameter int PADDLE_Y     = 464,
    parameter int R_SMALL      = 12,
    parameter int R_NORM       = 24,
    parameter int R_LARGE      = 40,
    parameter int BASE_SPEED   = 4,
`ifdef PADDLE_ACCEL_EN
    parameter int MAX_SPEED    = 8,
    parameter int ACCEL_FRAMES = 4,
`endif
    parameter int DEAD_FRAMES  = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_launch,
    input  logic       life_lost,
    input  logic       size_valid,
    input  logic [1:0] size_sel,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [5:0] radius,
    output logic       ball_hold,
    output logic       launch,
    output logic [1:0] state
);

    typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, DEAD = 2'd2} state_e;

    localparam logic [9:0]        X_HOME  = 10'(LEFT + MAXX / 2);
    localparam logic signed [10:0] LEFT_S  = 11'(LEFT);
    localparam logic signed [10:0] RIGHT_S = 11'(LEFT + MAXX);

    state_e     state_q, state_d;
    logic [9:0] x_q, x_d;
    logic [5:0] radius_q, radius_d;
    logic [5:0] target_q, target_d;
    logic       ball_hold_q, ball_hold_d;
    logic       launch_q, launch_d;
    logic       launch_pend_q, launch_pend_d;
    logic       launch_prev_q, launch_prev_d;
    logic [5:0] dead_cnt_q, dead_cnt_d;
`ifdef PADDLE_ACCEL_EN
    logic [3:0] spd_q, spd_d, acc_cnt_q, acc_cnt_d;
    logic       dir_q, dir_d;
    logic [3:0] spd_nx, acc_cnt_nx;
    logic       dir_nx;
`endif

    logic              one_held;
    logic [3:0]        spd_use;
    logic [5:0]        rad_next;
    logic [5:0]        size_radius;
    logic signed [10:0] step, x_sum, lo, hi;
    logic [9:0]        x_move;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        one_held = btn_left ^ btn_right;

`ifdef PADDLE_ACCEL_EN
        spd_use    = 4'd0;
        spd_nx     = 4'd0;
        acc_cnt_nx = 4'd0;
        dir_nx     = dir_q;
        if (one_held) begin
            if (spd_q != 4'd0 && dir_q == btn_right) begin
                if (acc_cnt_q == 4'(ACCEL_FRAMES)) begin
                    spd_use    = (spd_q >= 4'(MAX_SPEED)) ? spd_q : spd_q + 4'd1;
                    acc_cnt_nx = 4'd1;
                end else begin
                    spd_use    = spd_q;
                    acc_cnt_nx = acc_cnt_q + 4'd1;
                end
            end else begin
                // Fresh press or reversal restarts the ramp.
                spd_use    = 4'd1;
                acc_cnt_nx = 4'd1;
                dir_nx     = btn_right;
            end
            spd_nx = spd_use;
        end
`else
        spd_use = one_held ? 4'(BASE_SPEED) : 4'd0;
`endif

        if (radius_q < target_q)      rad_next = radius_q + 6'd1;
        else if (radius_q > target_q) rad_next = radius_q - 6'd1;
        else                          rad_next = radius_q;

        // Clamp against the radius written this tick so growth at a wall pushes inward.
        step = 11'sd0;
        if (btn_left && !btn_right)      step = -$signed({7'd0, spd_use});
        else if (btn_right && !btn_left) step = $signed({7'd0, spd_use});
        x_sum = $signed({1'b0, x_q}) + step;
        lo    = LEFT_S + $signed({5'd0, rad_next});
        hi    = RIGHT_S - $signed({5'd0, rad_next});
        if (x_sum < lo)      x_move = lo[9:0];
        else if (x_sum > hi) x_move = hi[9:0];
        else                 x_move = x_sum[9:0];

        case (size_sel)
            2'd0:    size_radius = 6'(R_SMALL);
            2'd1:    size_radius = 6'(R_NORM);
            default: size_radius = 6'(R_LARGE);
        endcase

        state_d       = state_q;
        x_d           = x_q;
        radius_d      = radius_q;
        target_d      = target_q;
        ball_hold_d   = ball_hold_q;
        launch_d      = 1'b0;
        launch_pend_d = launch_pend_q | (btn_launch & ~launch_prev_q);
        launch_prev_d = btn_launch;
        dead_cnt_d    = dead_cnt_q;
`ifdef PADDLE_ACCEL_EN
        spd_d     = spd_q;
        acc_cnt_d = acc_cnt_q;
        dir_d     = dir_q;
`endif

        case (state_q)
            SERVE, PLAY: begin
                if (state_q == PLAY) launch_pend_d = 1'b0;
                if (state_q == PLAY && life_lost) begin
                    state_d = DEAD;
                end else begin
                    if (size_valid && size_sel != 2'd3) target_d = size_radius;
                    if (frame_tick) begin
                        radius_d = rad_next;
                        x_d      = x_move;
`ifdef PADDLE_ACCEL_EN
                        spd_d     = spd_nx;
                        acc_cnt_d = acc_cnt_nx;
                        dir_d     = dir_nx;
`endif
                        if (state_q == SERVE && launch_pend_q) begin
                            state_d       = PLAY;
                            launch_d      = 1'b1;
                            ball_hold_d   = 1'b0;
                            launch_pend_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                launch_pend_d = 1'b0;
`ifdef PADDLE_ACCEL_EN
                spd_d     = 4'd0;
                acc_cnt_d = 4'd0;
`endif
                if (frame_tick) begin
                    if (dead_cnt_q == 6'(DEAD_FRAMES - 1)) begin
                        dead_cnt_d  = 6'd0;
                        state_d     = SERVE;
                        x_d         = X_HOME;
                        radius_d    = 6'(R_NORM);
                        target_d    = 6'(R_NORM);
                        ball_hold_d = 1'b1;
                    end else begin
                        dead_cnt_d = dead_cnt_q + 6'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SERVE;
            x_q           <= X_HOME;
            radius_q      <= 6'(R_NORM);
            target_q      <= 6'(R_NORM);
            ball_hold_q   <= 1'b1;
            launch_q      <= 1'b0;
            launch_pend_q <= 1'b0;
            launch_prev_q <= 1'b0;
            dead_cnt_q    <= 6'd0;
`ifdef PADDLE_ACCEL_EN
            spd_q     <= 4'd0;
            acc_cnt_q <= 4'd0;
            dir_q     <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q       <= state_d;
            x_q           <= x_d;
            radius_q      <= radius_d;
            target_q      <= target_d;
            ball_hold_q   <= ball_hold_d;
            launch_q      <= launch_d;
            launch_pend_q <= launch_pend_d;
            launch_prev_q <= launch_prev_d;
            dead_cnt_q    <= dead_cnt_d;
`ifdef PADDLE_ACCEL_EN
            spd_q     <= spd_d;
            acc_cnt_q <= acc_cnt_d;
            dir_q     <= dir_d;
`endif
        end
    end

    assign x         = x_q;
    assign y         = 10'(PADDLE_Y);
    assign radius    = radius_q;
    assign ball_hold = ball_hold_q;
    assign launch    = launch_q;
    assign state     = state_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed self-checking bench for paddle_ctrl: reset, clamping, launch, size
// animation, death sequence; acceleration steps when PADDLE_ACCEL_EN is defined.
module tb_paddle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick, btn_left, btn_right, btn_launch, life_lost, size_valid;
    logic [1:0] size_sel;
    logic [9:0] x, y;
    logic [5:0] radius;
    logic       ball_hold, launch;
    logic [1:0] state;

    int tests_run    = 0;
    int tests_failed = 0;

    paddle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_launch (btn_launch),
        .life_lost  (life_lost),
        .size_valid (size_valid),
        .size_sel   (size_sel),
        .x          (x),
        .y          (y),
        .radius     (radius),
        .ball_hold  (ball_hold),
        .launch     (launch),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are read at the same point.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
    endtask

    initial begin
        int exp_x;
        rst_n = 1'b0;
        {frame_tick, btn_left, btn_right, btn_launch, life_lost, size_valid} = '0;
        size_sel = 2'd0;
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();

        check("rst_x", 32'(x), 32'd320);
        check("rst_y", 32'(y), 32'd464);
        check("rst_radius", 32'(radius), 32'd24);
        check("rst_hold", 32'(ball_hold), 32'd1);
        check("rst_state", 32'(state), 32'd0);
        check("rst_launch", 32'(launch), 32'd0);

`ifdef PADDLE_ACCEL_EN
        btn_left = 1'b1;
        exp_x = 320;
        for (int k = 1; k <= 9; k++) begin
            frame();
            exp_x -= (k <= 4) ? 1 : (k <= 8) ? 2 : 3;
            check("accel_left_x", 32'(x), 32'(exp_x));
        end
        btn_left  = 1'b0;
        btn_right = 1'b1;
        frame();
        check("accel_rev_x", 32'(x), 32'(exp_x + 1));
        frame();
        check("accel_rev2_x", 32'(x), 32'(exp_x + 2));
        btn_right = 1'b0;
`else
        // Right held: +4 per tick, saturating at 480-24.
        btn_right = 1'b1;
        frame();
        check("right_first_x", 32'(x), 32'd324);
        repeat (3) cycle();
        check("no_tick_hold_x", 32'(x), 32'd324);
        for (int k = 2; k <= 100; k++) begin
            frame();
            exp_x = (320 + 4 * k > 456) ? 456 : 320 + 4 * k;
            check("right_sat_x", 32'(x), 32'(exp_x));
        end

        btn_launch = 1'b1;
        cycle();
        btn_launch = 1'b0;
        cycle();
        check("pre_tick_state", 32'(state), 32'd0);
        check("pre_tick_launch", 32'(launch), 32'd0);
        frame();
        check("launch_state", 32'(state), 32'd1);
        check("launch_pulse", 32'(launch), 32'd1);
        check("launch_hold", 32'(ball_hold), 32'd0);
        cycle();
        check("launch_drop", 32'(launch), 32'd0);

        // Growth against the right wall drags x inward each tick.
        size_valid = 1'b1;
        size_sel   = 2'd2;
        cycle();
        size_valid = 1'b0;
        check("size_not_yet", 32'(radius), 32'd24);
        for (int k = 1; k <= 16; k++) begin
            frame();
            check("grow_radius", 32'(radius), 32'(24 + k));
            check("grow_x", 32'(x), 32'(456 - k));
        end
        size_valid = 1'b1;
        size_sel   = 2'd3;
        cycle();
        size_valid = 1'b0;
        frame();
        check("sel3_radius", 32'(radius), 32'd40);
        check("sel3_x", 32'(x), 32'd440);

        btn_right = 1'b0;
        btn_left  = 1'b1;
        frame();
        check("left_x", 32'(x), 32'd436);
        btn_right = 1'b1;
        frame();
        check("both_x", 32'(x), 32'd436);
        btn_right = 1'b0;

        life_lost  = 1'b1;
        size_valid = 1'b1;
        size_sel   = 2'd0;
        cycle();
        life_lost  = 1'b0;
        size_valid = 1'b0;
        check("dead_state", 32'(state), 32'd2);
        check("dead_radius", 32'(radius), 32'd40);
        repeat (59) frame();
        check("dead59_state", 32'(state), 32'd2);
        check("dead59_x", 32'(x), 32'd436);
        check("dead59_radius", 32'(radius), 32'd40);
        frame();
        check("respawn_state", 32'(state), 32'd0);
        check("respawn_x", 32'(x), 32'd320);
        check("respawn_radius", 32'(radius), 32'd24);
        check("respawn_hold", 32'(ball_hold), 32'd1);
        btn_left = 1'b0;
        frame();
        check("target_reset_radius", 32'(radius), 32'd24);

        life_lost = 1'b1;
        cycle();
        life_lost = 1'b0;
        check("serve_life_lost", 32'(state), 32'd0);
        check("end_y", 32'(y), 32'd464);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
